data_mem_responder: RTL and testbench

Data-memory responder on the far end of the CPU pipeline's load/store port. It accepts word reads and writes issued from the memory stage and returns load data with a fixed two-cycle latency, so data is valid in the LDR write-back stage. After reset it clears its storage with a sweep state machine and holds `ready` low until the sweep completes.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_array.sv | 38 +++
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 tb/tb_data_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  // Sweep-then-serve control states.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mem_state_t;

  localparam int WORD_W   = 32;
  localparam int ADDR_LSB = 2;

  // A byte address is unusable when it is not word aligned or when any bit
  // above the word-index field is set (address beyond the array).
  function automatic logic addr_bad(input logic [31:0] addr, input int idx_w);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[ADDR_LSB-1:0] != 2'b00);
    out_of_range = ((addr >> (idx_w + ADDR_LSB)) != 32'd0);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 simple dual-port synchronous RAM: one write port, one
// registered read port with read-first behaviour. Storage is not reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] rdata_r;

  // Commit writes on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Register the addressed word; a same-edge write is not yet visible,
  // so a colliding read returns the old contents.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: zeroes the array after reset, then serves word
// reads/writes with a fixed two-cycle load latency and error flagging.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       mem_addr,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              rvalid,
  output logic              err,
  output logic              ready
);

  // The sweep counter carries one extra bit so the terminal compare never wraps.
  localparam logic [IDX_W:0] CLR_LAST = (IDX_W+1)'(DEPTH - 1);
  localparam logic [IDX_W:0] CLR_STEP = (IDX_W+1)'(1);

  mem_state_t        state_r;
  mem_state_t        state_nxt_s;
  logic [IDX_W:0]    clr_idx_r;
  logic [IDX_W:0]    clr_idx_nxt_s;

  logic              in_run_s;
  logic              bad_s;
  logic [IDX_W-1:0]  idx_s;
  logic              rd_go_s;
  logic              wr_go_s;

  logic              arr_we_s;
  logic [IDX_W-1:0]  arr_waddr_s;
  logic [WORD_W-1:0] arr_wdata_s;
  logic [WORD_W-1:0] arr_rdata_s;

  logic              s1_rvalid_r;
  logic              s1_bad_rd_r;
  logic              s1_err_r;

  // Next-state logic: walk every index in CLEAR, then stay in RUN.
  always_comb begin
    state_nxt_s   = state_r;
    clr_idx_nxt_s = clr_idx_r;
    case (state_r)
      CLEAR: begin
        clr_idx_nxt_s = clr_idx_r + CLR_STEP;
        if (clr_idx_r == CLR_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = CLEAR;
        end
      end
      RUN: begin
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s   = CLEAR;
        clr_idx_nxt_s = '0;
      end
    endcase
  end

  // State, sweep counter and ready flag; ready tracks the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= CLEAR;
      clr_idx_r <= '0;
      ready     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      clr_idx_r <= clr_idx_nxt_s;
      ready     <= (state_nxt_s == RUN);
    end
  end

  // Decode the request; nothing is accepted until the sweep has finished.
  always_comb begin
    in_run_s = (state_r == RUN);
    bad_s    = addr_bad(mem_addr, IDX_W);
    idx_s    = mem_addr[IDX_W+ADDR_LSB-1:ADDR_LSB];
    rd_go_s  = in_run_s & mem_r_en;
    wr_go_s  = in_run_s & mem_w_en & ~bad_s;
  end

  // Write-port mux: the sweep owns the port in CLEAR, CPU stores in RUN.
  always_comb begin
    arr_we_s    = 1'b0;
    arr_waddr_s = '0;
    arr_wdata_s = '0;
    if (state_r == CLEAR) begin
      arr_we_s    = 1'b1;
      arr_waddr_s = clr_idx_r[IDX_W-1:0];
      arr_wdata_s = '0;
    end else begin
      arr_we_s    = wr_go_s;
      arr_waddr_s = idx_s;
      arr_wdata_s = mem_wdata;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (arr_we_s),
    .waddr (arr_waddr_s),
    .wdata (arr_wdata_s),
    .re    (rd_go_s & ~bad_s),
    .raddr (idx_s),
    .rdata (arr_rdata_s)
  );

  // Stage 1: control bits travelling alongside the array's registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rvalid_r <= 1'b0;
      s1_bad_rd_r <= 1'b0;
      s1_err_r    <= 1'b0;
    end else begin
      s1_rvalid_r <= rd_go_s;
      s1_bad_rd_r <= rd_go_s & bad_s;
      s1_err_r    <= in_run_s & (mem_r_en | mem_w_en) & bad_s;
    end
  end

  // Stage 2: present the result; data is forced to zero unless it is a good read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata <= 32'd0;
      rvalid    <= 1'b0;
      err       <= 1'b0;
    end else begin
      rvalid <= s1_rvalid_r;
      err    <= s1_err_r;
      if (s1_rvalid_r && !s1_bad_rd_r) begin
        mem_rdata <= arr_rdata_s;
      end else begin
        mem_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a transaction-level model
// predicts every output cycle, plus hand-computed directed expectations.
module tb_data_mem_responder;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mem_addr = 32'd0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] mem_wdata = 32'd0;
  logic [31:0] mem_rdata;
  logic        rvalid;
  logic        err;
  logic        ready;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_addr  (mem_addr),
    .mem_r_en  (mem_r_en),
    .mem_w_en  (mem_w_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .rvalid    (rvalid),
    .err       (err),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] mdl_mem [DEPTH];
  int          m_edges;
  logic        m_ready;
  logic        m_pv, m_pe, m_rv, m_e;
  logic [31:0] m_pdata, m_rdata;

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH * 4);
  endfunction

  // Model: sweep takes DEPTH edges; each accepted request yields its result
  // one edge into a pending slot and the next edge onto the outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_ready <= 1'b0;
      m_pv <= 1'b0; m_pe <= 1'b0; m_pdata <= 32'd0;
      m_rv <= 1'b0; m_e <= 1'b0;  m_rdata <= 32'd0;
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] <= 32'd0;
    end else begin
      if (m_edges < DEPTH) m_edges <= m_edges + 1;
      m_ready <= (m_edges + 1 >= DEPTH);
      m_rv    <= m_pv;
      m_e     <= m_pe;
      m_rdata <= m_pdata;
      if (m_ready) begin
        m_pv <= mem_r_en;
        m_pe <= (mem_r_en || mem_w_en) && is_bad(mem_addr);
        if (mem_r_en && !is_bad(mem_addr)) m_pdata <= mdl_mem[mem_addr / 4];
        else                               m_pdata <= 32'd0;
        if (mem_w_en && !is_bad(mem_addr)) mdl_mem[mem_addr / 4] <= mem_wdata;
      end else begin
        m_pv <= 1'b0; m_pe <= 1'b0; m_pdata <= 32'd0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model rdata",  mem_rdata,       m_rdata);
    check("model rvalid", {31'd0, rvalid}, {31'd0, m_rv});
    check("model err",    {31'd0, err},    {31'd0, m_e});
    check("model ready",  {31'd0, ready},  {31'd0, m_ready});
  endtask

  // One clock: advance past the edge, then compare against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    mem_r_en = r; mem_w_en = w; mem_addr = a; mem_wdata = d;
    tick();
    mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] d, input bit v, input bit e);
    check({name, " rdata"},  mem_rdata,       d);
    check({name, " rvalid"}, {31'd0, rvalid}, {31'd0, v});
    check({name, " err"},    {31'd0, err},    {31'd0, e});
  endtask

  // Count edges until ready; optionally poke requests mid-sweep. Any output
  // activity during the sweep is recorded as stale.
  task automatic wait_ready(input bit poke, output int cnt, output bit stale);
    cnt = 0;
    stale = 1'b0;
    while (cnt < 400) begin
      if (poke && cnt == 100) begin
        mem_r_en = 1'b1; mem_w_en = 1'b1; mem_addr = 32'h0; mem_wdata = 32'hFFFF_FFFF;
      end
      if (poke && cnt == 102) begin
        mem_r_en = 1'b0; mem_w_en = 1'b0; mem_wdata = 32'd0;
      end
      tick();
      cnt++;
      if (rvalid || err) stale = 1'b1;
      if (ready) break;
    end
  endtask

  int cnt;
  bit stale;

  initial begin
    // Power-on reset (start high so the DUT sees a real falling edge).
    #2 rst_n = 1'b0;
    #3;
    expect_out("reset", 32'd0, 1'b0, 1'b0);
    check("reset ready", {31'd0, ready}, 32'd0);
    repeat (3) tick();
    @(negedge clk) rst_n = 1'b1;

    // Sweep length and requests ignored while clearing.
    wait_ready(1'b1, cnt, stale);
    check("sweep cycles", cnt, 32'd256);
    check("sweep quiet", {31'd0, stale}, 32'd0);

    // Location 0 was zeroed by the sweep and the mid-sweep write was dropped.
    req(1'b1, 1'b0, 32'h0, 32'd0);
    tick();
    expect_out("read0 zero", 32'd0, 1'b1, 1'b0);

    // Write then read next cycle.
    req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 32'h10, 32'd0);
    tick();
    expect_out("wr-rd 0x10", 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Same-cycle read/write to one index is read-first.
    req(1'b0, 1'b1, 32'h20, 32'hAAAA_0000);
    req(1'b1, 1'b1, 32'h20, 32'h1234_5678);
    tick();
    expect_out("collide old", 32'hAAAA_0000, 1'b1, 1'b0);
    req(1'b1, 1'b0, 32'h20, 32'd0);
    tick();
    expect_out("collide new", 32'h1234_5678, 1'b1, 1'b0);

    // Bad accesses.
    req(1'b1, 1'b0, 32'h402, 32'd0);
    tick();
    expect_out("rd misalign", 32'd0, 1'b1, 1'b1);
    req(1'b1, 1'b0, 32'h400, 32'd0);
    tick();
    expect_out("rd range", 32'd0, 1'b1, 1'b1);
    req(1'b0, 1'b1, 32'h400, 32'hCAFE_F00D);
    tick();
    expect_out("wr range", 32'd0, 1'b0, 1'b1);
    req(1'b0, 1'b1, 32'h13, 32'h5555_5555);
    tick();
    expect_out("wr misalign", 32'd0, 1'b0, 1'b1);

    // Seed words, then back-to-back reads 0x0 / 0x4 / 0x8.
    req(1'b0, 1'b1, 32'h4, 32'h0000_0044);
    req(1'b0, 1'b1, 32'h8, 32'h0000_0088);
    mem_r_en = 1'b1; mem_addr = 32'h0;
    tick();
    mem_addr = 32'h4;
    tick();
    expect_out("b2b 0x0", 32'd0, 1'b1, 1'b0);
    mem_addr = 32'h8;
    tick();
    expect_out("b2b 0x4", 32'h0000_0044, 1'b1, 1'b0);
    mem_r_en = 1'b0; mem_addr = 32'h0;
    tick();
    expect_out("b2b 0x8", 32'h0000_0088, 1'b1, 1'b0);
    req(1'b1, 1'b0, 32'h10, 32'd0);
    tick();
    expect_out("0x10 kept", 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Reset with two reads in flight.
    req(1'b1, 1'b0, 32'h4, 32'd0);
    req(1'b1, 1'b0, 32'h8, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    expect_out("async rst", 32'd0, 1'b0, 1'b0);
    check("async rst ready", {31'd0, ready}, 32'd0);
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    wait_ready(1'b0, cnt, stale);
    check("resweep cycles", cnt, 32'd256);
    check("resweep quiet", {31'd0, stale}, 32'd0);
    req(1'b1, 1'b0, 32'h10, 32'd0);
    tick();
    expect_out("resweep 0x10", 32'd0, 1'b1, 1'b0);
    tick();
    expect_out("idle", 32'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
